// File: rtl/cook_timer_ctrl_pkg.sv
// Shared types and constants for the microwave cook timer sequencer.
package cook_timer_ctrl_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned DONE_CNT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX  = 4'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } bcd_time_t;

endpackage

// File: rtl/cook_timer_ctrl_if.sv
// Keypad / 1 Hz input stage and display / actuator signals of the cook timer.
interface cook_timer_ctrl_if;
  import cook_timer_ctrl_pkg::*;

  logic [DIGIT_W-1:0] BCD;
  logic               loadn;
  logic               pgt_1Hz;
  logic               start;
  logic               stop;
  logic               door_closed;
  logic               keypad_en;
  logic [DIGIT_W-1:0] sec_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] min_tens;
  logic               magnetron_on;
  logic               done;

  modport master (
    output BCD, loadn, pgt_1Hz, start, stop, door_closed,
    input  keypad_en, sec_ones, sec_tens, min_ones, min_tens, magnetron_on, done
  );

  modport slave (
    input  BCD, loadn, pgt_1Hz, start, stop, door_closed,
    output keypad_en, sec_ones, sec_tens, min_ones, min_tens, magnetron_on, done
  );

endinterface

// File: rtl/cook_timer_ctrl_bcd_time_reg.sv
// Four-digit mm:ss BCD register with clear, shift-in and borrow-chain decrement.
module bcd_time_reg
  import cook_timer_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_shift,
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic               i_dec,
  output bcd_time_t          o_time,
  output logic               o_zero_c,
  output logic               o_dec_zero_c
);

  bcd_time_t r_time;
  bcd_time_t w_dec_time;
  logic      w_zero;

  assign w_zero = (r_time == '0);

  // Borrow ripples from seconds units up to minutes tens.
  always_comb begin
    w_dec_time = r_time;
    if (r_time.sec_ones != '0) begin
      w_dec_time.sec_ones = r_time.sec_ones - 4'd1;
    end else begin
      w_dec_time.sec_ones = BCD_MAX_DIGIT;
      if (r_time.sec_tens != '0) begin
        w_dec_time.sec_tens = r_time.sec_tens - 4'd1;
      end else begin
        w_dec_time.sec_tens = SEC_TENS_MAX;
        if (r_time.min_ones != '0) begin
          w_dec_time.min_ones = r_time.min_ones - 4'd1;
        end else begin
          w_dec_time.min_ones = BCD_MAX_DIGIT;
          w_dec_time.min_tens = r_time.min_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_time <= '0;
    end else if (i_clr) begin
      r_time <= '0;
    end else if (i_shift) begin
      r_time <= '{min_tens: r_time.min_ones,
                  min_ones: r_time.sec_tens,
                  sec_tens: r_time.sec_ones,
                  sec_ones: i_digit};
    end else if (i_dec && !w_zero) begin
      r_time <= w_dec_time;
    end
  end

  assign o_time       = r_time;
  assign o_zero_c     = w_zero;
  assign o_dec_zero_c = !w_zero && (w_dec_time == '0);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave timer sequencer: keypad entry, countdown on 1 Hz ticks, pause and done handling.
module cook_timer_ctrl
  import cook_timer_ctrl_pkg::*;
#(
  parameter int unsigned DONE_TICKS = 3
)(
  input logic              clock,
  input logic              clearn,
  cook_timer_ctrl_if.slave bus
);

  localparam logic [DONE_CNT_W-1:0] DONE_CNT_LAST = DONE_CNT_W'(DONE_TICKS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_loadn_q;
  logic                  r_pgt_q;
  logic                  r_strobe;
  logic                  r_tick;
  logic [DIGIT_W-1:0]    r_bcd;
  logic [DONE_CNT_W-1:0] r_done_cnt;
  logic [DONE_CNT_W-1:0] w_done_cnt_nxt;
  logic                  r_keypad_en;
  logic                  r_magnetron;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_clr;
  logic                  w_shift;
  logic                  w_dec;
  logic                  w_zero;
  logic                  w_dec_zero;
  bcd_time_t             w_time;

  assign w_accept = r_strobe && (r_bcd <= BCD_MAX_DIGIT);

  bcd_time_reg u_time (
    .i_clk        (clock),
    .i_rst_n      (clearn),
    .i_clr        (w_clr),
    .i_shift      (w_shift),
    .i_digit      (r_bcd),
    .i_dec        (w_dec),
    .o_time       (w_time),
    .o_zero_c     (w_zero),
    .o_dec_zero_c (w_dec_zero)
  );

  always_ff @(posedge clock) begin
    if (!clearn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Priority: stop > door open > start > tick > key strobe.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr          = 1'b0;
    w_shift        = 1'b0;
    w_dec          = 1'b0;
    w_done_cnt_nxt = r_done_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!bus.stop && w_accept) begin
          w_shift     = 1'b1;
          w_state_nxt = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (bus.stop) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (bus.start && bus.door_closed && !w_zero) begin
          w_state_nxt = ST_COOK;
        end else if (w_accept) begin
          w_shift = 1'b1;
        end
      end
      ST_COOK: begin
        if (bus.stop || !bus.door_closed) begin
          w_state_nxt = ST_PAUSE;
        end else if (r_tick) begin
          w_dec = 1'b1;
          if (w_dec_zero) begin
            w_state_nxt    = ST_DONE;
            w_done_cnt_nxt = '0;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (bus.start && bus.door_closed) begin
          w_state_nxt = ST_COOK;
        end
      end
      ST_DONE: begin
        if (bus.stop || !bus.door_closed) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_tick) begin
          if (r_done_cnt >= DONE_CNT_LAST) begin
            w_state_nxt    = ST_IDLE;
            w_done_cnt_nxt = '0;
          end else begin
            w_done_cnt_nxt = r_done_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_clr       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Edge detectors, done counter and registered outputs follow the next state.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      r_loadn_q   <= 1'b1;
      r_pgt_q     <= 1'b0;
      r_strobe    <= 1'b0;
      r_tick      <= 1'b0;
      r_bcd       <= '0;
      r_done_cnt  <= '0;
      r_keypad_en <= 1'b1;
      r_magnetron <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_loadn_q   <= bus.loadn;
      r_pgt_q     <= bus.pgt_1Hz;
      r_strobe    <= r_loadn_q && !bus.loadn;
      r_tick      <= bus.pgt_1Hz && !r_pgt_q;
      r_bcd       <= bus.BCD;
      r_done_cnt  <= w_done_cnt_nxt;
      r_keypad_en <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ENTRY);
      r_magnetron <= (w_state_nxt == ST_COOK);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.keypad_en    = r_keypad_en;
  assign bus.magnetron_on = r_magnetron;
  assign bus.done         = r_done;
  assign bus.sec_ones     = w_time.sec_ones;
  assign bus.sec_tens     = w_time.sec_tens;
  assign bus.min_ones     = w_time.min_ones;
  assign bus.min_tens     = w_time.min_tens;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl: entry, countdown, borrow, pause, done and reset abort.
module tb_cook_timer_ctrl;

  logic clock;
  logic clearn;
  int   n_err;
  int   n_checks;

  cook_timer_ctrl_if bus();

  cook_timer_ctrl #(.DONE_TICKS(3)) dut (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tm();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic press(input logic [3:0] d);
    bus.BCD   = d;
    bus.loadn = 1'b0;
    step(5);
    bus.loadn = 1'b1;
    step(3);
  endtask

  task automatic tick();
    bus.pgt_1Hz = 1'b1;
    step(3);
    bus.pgt_1Hz = 1'b0;
    step(2);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
  endtask

  initial begin
    n_err           = 0;
    n_checks        = 0;
    clearn          = 1'b0;
    bus.BCD         = 4'd0;
    bus.loadn       = 1'b1;
    bus.pgt_1Hz     = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.door_closed = 1'b1;
    step(3);
    clearn = 1'b1;
    step(1);
    chk("rst_time", tm(), 16'h0000);
    chk("rst_keypad_en", 16'(bus.keypad_en), 16'd1);
    chk("rst_magnetron", 16'(bus.magnetron_on), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);

    // Held keys shift exactly once each.
    press(4'd1);
    chk("entry_1", tm(), 16'h0001);
    press(4'd3);
    chk("entry_13", tm(), 16'h0013);
    press(4'd0);
    chk("entry_130", tm(), 16'h0130);
    chk("entry_keypad_en", 16'(bus.keypad_en), 16'd1);
    pulse_stop();
    chk("entry_stop_clear", tm(), 16'h0000);

    // Two-second cook through DONE and back to IDLE.
    press(4'd0); press(4'd0); press(4'd0); press(4'd2);
    chk("cook2_entry", tm(), 16'h0002);
    pulse_start();
    chk("cook2_mag_on", 16'(bus.magnetron_on), 16'd1);
    chk("cook2_keypad_off", 16'(bus.keypad_en), 16'd0);
    tick();
    chk("cook2_tick1", tm(), 16'h0001);
    chk("cook2_tick1_mag", 16'(bus.magnetron_on), 16'd1);
    tick();
    chk("cook2_tick2", tm(), 16'h0000);
    chk("cook2_done", 16'(bus.done), 16'd1);
    chk("cook2_mag_off", 16'(bus.magnetron_on), 16'd0);
    chk("cook2_done_keypad", 16'(bus.keypad_en), 16'd0);
    tick();
    tick();
    chk("done_hold_2ticks", 16'(bus.done), 16'd1);
    tick();
    chk("done_release", 16'(bus.done), 16'd0);
    chk("done_idle_keypad", 16'(bus.keypad_en), 16'd1);

    // Borrow across seconds tens and minutes.
    press(4'd1); press(4'd0); press(4'd0);
    chk("borrow_entry", tm(), 16'h0100);
    pulse_start();
    tick();
    chk("borrow_0100", tm(), 16'h0059);
    pulse_stop();
    pulse_stop();
    chk("borrow_cancel", tm(), 16'h0000);
    press(4'd9); press(4'd9);
    pulse_start();
    tick();
    chk("dec_0099", tm(), 16'h0098);
    pulse_stop();
    pulse_stop();

    // Door opens on the same cycle a tick is acted on.
    press(4'd3); press(4'd0);
    pulse_start();
    chk("door_cook_on", 16'(bus.magnetron_on), 16'd1);
    bus.pgt_1Hz = 1'b1;
    step(1);
    bus.door_closed = 1'b0;
    step(2);
    bus.pgt_1Hz = 1'b0;
    step(2);
    chk("door_pause_time", tm(), 16'h0030);
    chk("door_pause_mag", 16'(bus.magnetron_on), 16'd0);
    pulse_start();
    step(1);
    chk("pause_start_open", 16'(bus.magnetron_on), 16'd0);
    bus.door_closed = 1'b1;
    step(1);
    pulse_start();
    chk("resume_mag", 16'(bus.magnetron_on), 16'd1);
    chk("resume_time", tm(), 16'h0030);
    tick();
    chk("resume_tick", tm(), 16'h0029);
    pulse_stop();
    pulse_stop();

    // Start refused in ENTRY with zero time or open door.
    press(4'd0);
    pulse_start();
    step(1);
    chk("entry_zero_start", 16'(bus.magnetron_on), 16'd0);
    chk("entry_zero_keypad", 16'(bus.keypad_en), 16'd1);
    press(4'd5);
    chk("entry_after_zero", tm(), 16'h0005);
    bus.door_closed = 1'b0;
    pulse_start();
    step(1);
    chk("entry_open_start", 16'(bus.magnetron_on), 16'd0);
    bus.door_closed = 1'b1;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    step(1);
    chk("stop_start_time", tm(), 16'h0000);
    chk("stop_start_mag", 16'(bus.magnetron_on), 16'd0);

    // Invalid digit, five-digit overflow, reset during cook.
    press(4'hA);
    chk("bcd_invalid", tm(), 16'h0000);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    chk("five_digits", tm(), 16'h2345);
    pulse_start();
    chk("rst_cook_mag", 16'(bus.magnetron_on), 16'd1);
    clearn = 1'b0;
    step(1);
    chk("abort_time", tm(), 16'h0000);
    chk("abort_mag", 16'(bus.magnetron_on), 16'd0);
    chk("abort_keypad", 16'(bus.keypad_en), 16'd1);
    clearn = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cook_timer_ctrl.md
Name: cook_timer_ctrl

Overview:
Sequencer for the keypad/1 Hz input stage of the microwave timer. It shifts keypad BCD digits into a 4-digit mm:ss register and gates the keypad encoder through keypad_en. On start it counts the time down on each 1 Hz tick, driving the magnetron, handling door/pause and signalling completion. It sits between the input stage (BCD, loadn, pgt_1Hz) and the display/actuator logic.

Parameters:
DONE_TICKS, 3, number of 1 Hz ticks the done flag stays asserted before returning to IDLE (1..15)

Ports:
clock  in  1  system clock
clearn  in  1  synchronous active-low reset
BCD  in  4  keypad digit from the encoder, valid while loadn is low
loadn  in  1  active-low key-valid from the encoder
pgt_1Hz  in  1  1 Hz square wave, synchronous to clock
start  in  1  start/resume request, one-cycle pulse
stop  in  1  pause/cancel request, one-cycle pulse
door_closed  in  1  level, 1 = door closed
keypad_en  out  1  enable to the input stage; 1 = keypad accepted
sec_ones  out  4  BCD seconds units
sec_tens  out  4  BCD seconds tens
min_ones  out  4  BCD minutes units
min_tens  out  4  BCD minutes tens
magnetron_on  out  1  heating active
done  out  1  cook cycle complete

Behaviour:
- Reset (clearn=0 at a clock edge): state IDLE, all digits 0, magnetron_on=0, done=0, keypad_en=1, edge detectors cleared (loadn_q=1, pgt_q=0).
- Digit strobe: first cycle with loadn=0 after loadn=1 (falling-edge detect, registered). A held key yields exactly one strobe. Strobes with BCD>9 are ignored.
- tick: rising edge of pgt_1Hz, one cycle wide, delayed 1 cycle after the input edge.
- Shift-in on accepted strobe: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=BCD. A fifth digit drops the oldest. sec_tens may hold 6..9 after entry; this is legal.
- Decrement on tick, BCD with borrow:
  - sec_ones>0: sec_ones-1.
  - Otherwise sec_ones=9 and borrow from sec_tens (sec_tens>0: sec_tens-1; else sec_tens=5, borrow into minutes).
  - Minutes borrow the same way, with min_ones wrapping to 9.
  - Never decremented at 0000.
- States:
  - IDLE: keypad_en=1, digits hold 0000.
    - Strobe: shift in and go to ENTRY.
    - start: ignored.
  - ENTRY: keypad_en=1.
    - Strobe: shift in.
    - stop: clear to 0000, go to IDLE.
    - start & door_closed & time!=0000: go to COOK.
    - start with door open or time 0000: ignored.
  - COOK: keypad_en=0, magnetron_on=1.
    - stop or !door_closed: go to PAUSE, no decrement that cycle.
    - Otherwise tick: decrement. If the result is 0000, go to DONE in the same edge.
  - PAUSE: keypad_en=0, magnetron_on=0, time held.
    - stop: clear to 0000, go to IDLE.
    - start & door_closed: go to COOK.
  - DONE: done=1, magnetron_on=0, keypad_en=0, time 0000, internal tick counter loaded with 0.
    - Each tick increments the counter. When the count reaches DONE_TICKS, go to IDLE.
    - stop or door opening: go to IDLE immediately.
- Priority in any single cycle: reset > stop > door open > start > tick > strobe.
- Latency: outputs are registered; magnetron_on rises 1 cycle after the start pulse; the digit update appears 2 cycles after the loadn falling edge.
- Reset mid-COOK aborts the cycle: all outputs return to reset values on the next edge.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_ENTRY, ST_COOK, ST_PAUSE, ST_DONE (3 bits);
  - BCD_MAX_DIGIT=9;
  - SEC_TENS_MAX=5.
- One sub-module, bcd_time_reg: 4-digit register with clear, shift-in and decrement-with-borrow controls, plus a zero flag.
- The FSM, edge detectors and done counter live in cook_timer_ctrl.

Test Plan:
- Reset, then press keys 1,3,0 (loadn low 5 cycles each) -> digits 0130. Each key held multiple cycles shifts once. keypad_en=1.
- Enter 0,0,0,2, door_closed=1, start -> magnetron_on=1 next cycle. After 1st tick: 0001. After 2nd tick: 0000, done=1, magnetron_on=0. After 3 more ticks: IDLE, done=0.
- Enter 1,0,0 (1:00), start, one tick -> 0059. Enter 9,9, start, one tick -> 0098. 0100 at tick -> 0059 (borrow across tens).
- COOK at 0030; deassert door_closed on the same cycle as a tick -> PAUSE, time stays 0030. start with door open -> stays PAUSE. Close door, start -> COOK resumes from 0030.
- In ENTRY, assert start with time 0000 or with the door open -> stays ENTRY. stop and start in the same cycle -> IDLE, time 0000.
- Key BCD=4'hA -> ignored. Five digits 1,2,3,4,5 -> 2345. clearn low during COOK -> IDLE, 0000, magnetron_on=0.
